// File: rtl/btb_pkg.sv
// Branch target buffer types: entry layout and the 2-bit saturating counter step.
package btb_pkg;

    localparam int BTB_ADDR_WIDTH  = 32;
    localparam int BTB_NUM_SETS    = 64;
    localparam int BTB_INDEX_WIDTH = $clog2(BTB_NUM_SETS);
    localparam int BTB_TAG_WIDTH   = BTB_ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

    // Entry field widths follow the package defaults above.
    typedef struct packed {
        logic                      valid;
        logic [BTB_TAG_WIDTH-1:0]  tag;
        logic [BTB_ADDR_WIDTH-1:0] target;
        logic [1:0]                ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/mips_core_pkg.sv
// Core-wide shared types. BranchOutcome is the resolved-branch direction
// reported by the EX stage to every branch predictor structure.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

endpackage

// File: rtl/btb_way.sv
// One BTB way: per-set entry storage with two combinational read/compare
// ports (fetch lookup, EX update) and one registered write port.
module btb_way
    import btb_pkg::*;
#(
    parameter int NUM_SETS = BTB_NUM_SETS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [$clog2(NUM_SETS)-1:0]     lk_index_i,
    input  logic [BTB_TAG_WIDTH-1:0]        lk_tag_i,
    output logic                            lk_hit_o,
    output btb_entry_t                      lk_entry_o,
    input  logic [$clog2(NUM_SETS)-1:0]     up_index_i,
    input  logic [BTB_TAG_WIDTH-1:0]        up_tag_i,
    output logic                            up_hit_o,
    output btb_entry_t                      up_entry_o,
    input  logic                            wr_en_i,
    input  logic [$clog2(NUM_SETS)-1:0]     wr_index_i,
    input  btb_entry_t                      wr_entry_i
);

    logic [NUM_SETS-1:0]       valid_q;
    logic [NUM_SETS-1:0]       valid_d;
    logic [BTB_TAG_WIDTH-1:0]  tag_q    [NUM_SETS];
    logic [BTB_ADDR_WIDTH-1:0] target_q [NUM_SETS];
    logic [1:0]                ctr_q    [NUM_SETS];

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_index_i] = wr_entry_i.valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]    <= wr_entry_i.tag;
            target_q[wr_index_i] <= wr_entry_i.target;
            ctr_q[wr_index_i]    <= wr_entry_i.ctr;
        end
    end

    always_comb begin
        lk_entry_o.valid  = valid_q[lk_index_i];
        lk_entry_o.tag    = tag_q[lk_index_i];
        lk_entry_o.target = target_q[lk_index_i];
        lk_entry_o.ctr    = ctr_q[lk_index_i];
        up_entry_o.valid  = valid_q[up_index_i];
        up_entry_o.tag    = tag_q[up_index_i];
        up_entry_o.target = target_q[up_index_i];
        up_entry_o.ctr    = ctr_q[up_index_i];
    end

    assign lk_hit_o = lk_entry_o.valid && (lk_entry_o.tag == lk_tag_i);
    assign up_hit_o = up_entry_o.valid && (up_entry_o.tag == up_tag_i);

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-stage 2-way set-associative BTB: zero-latency lookup, EX-trained,
// per-set LRU victim bit and per-entry 2-bit saturating taken counter.
module branch_target_buffer
    import mips_core_pkg::*;
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH = BTB_ADDR_WIDTH,
    parameter int NUM_SETS   = BTB_NUM_SETS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_lookup_valid,
    input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                  o_hit,
    output logic [ADDR_WIDTH-1:0] o_target,
    output logic                  o_predict_taken,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  logic [ADDR_WIDTH-1:0] i_upd_target,
    input  BranchOutcome          i_upd_outcome,
    input  logic                  i_upd_is_jump,
    input  logic                  i_flush_all
);

    localparam int INDEX_WIDTH = $clog2(NUM_SETS);
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2;

    // i_lookup_valid and i_upd_valid are single-cycle qualifiers with no
    // ready: the BTB accepts a lookup and an update every cycle.
    logic [INDEX_WIDTH-1:0] lk_index, up_index;
    logic [TAG_WIDTH-1:0]   lk_tag, up_tag;
    logic [1:0]             lk_hit, up_hit, wr_en;
    btb_entry_t             lk_entry [2];
    btb_entry_t             up_entry [2];
    btb_entry_t             wr_entry;
    logic [NUM_SETS-1:0]    lru_q, lru_d;
    logic                   lk_hit_any, lk_way, up_hit_any, up_way, victim, wr_way;
    logic                   unused_bits;

    assign lk_index = i_lookup_pc[INDEX_WIDTH+1:2];
    assign lk_tag   = i_lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign up_index = i_upd_pc[INDEX_WIDTH+1:2];
    assign up_tag   = i_upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(.NUM_SETS(NUM_SETS)) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (i_flush_all),
            .lk_index_i (lk_index),
            .lk_tag_i   (lk_tag),
            .lk_hit_o   (lk_hit[w]),
            .lk_entry_o (lk_entry[w]),
            .up_index_i (up_index),
            .up_tag_i   (up_tag),
            .up_hit_o   (up_hit[w]),
            .up_entry_o (up_entry[w]),
            .wr_en_i    (wr_en[w]),
            .wr_index_i (up_index),
            .wr_entry_i (wr_entry)
        );
    end

    // A double hit cannot be created by allocation; way0 wins if it appears.
    assign lk_hit_any      = i_lookup_valid && (|lk_hit);
    assign lk_way          = !lk_hit[0];
    assign o_hit           = lk_hit_any;
    assign o_target        = !lk_hit_any ? '0 :
                             (lk_hit[0] ? lk_entry[0].target : lk_entry[1].target);
    assign o_predict_taken = lk_hit_any &&
                             (lk_hit[0] ? lk_entry[0].ctr[1] : lk_entry[1].ctr[1]);

    assign up_hit_any = |up_hit;
    assign up_way     = !up_hit[0];
    assign victim     = !up_entry[0].valid ? 1'b0 :
                        !up_entry[1].valid ? 1'b1 : lru_q[up_index];

    always_comb begin
        wr_en           = '0;
        wr_way          = 1'b0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = up_tag;
        wr_entry.target = i_upd_target;
        wr_entry.ctr    = 2'b10;
        if (i_upd_valid && !i_flush_all) begin
            if (up_hit_any) begin
                wr_way       = up_way;
                wr_entry.ctr = i_upd_is_jump ? 2'b11 :
                               ctr_next(up_entry[up_way].ctr, i_upd_outcome == TAKEN);
                wr_en[up_way] = 1'b1;
            end else if (i_upd_is_jump || i_upd_outcome == TAKEN) begin
                wr_way       = victim;
                wr_entry.ctr = i_upd_is_jump ? 2'b11 : 2'b10;
                wr_en[victim] = 1'b1;
            end
        end
    end

    // Update's LRU write is applied last so it wins over a same-set lookup hit.
    always_comb begin
        lru_d = lru_q;
        if (i_flush_all) begin
            lru_d = '0;
        end else begin
            if (lk_hit_any) begin
                lru_d[lk_index] = ~lk_way;
            end
            if (|wr_en) begin
                lru_d[up_index] = ~wr_way;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

    assign unused_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0],
                           lk_entry[0].valid, lk_entry[0].tag,
                           lk_entry[1].valid, lk_entry[1].tag,
                           up_entry[0].tag, up_entry[0].target,
                           up_entry[1].tag, up_entry[1].target};

endmodule
